// File: rtl/mem_data_access.sv
// Memory-stage load/store engine: one transaction at a time on a split-handshake data-SRAM bus.
// Optional feature: define MEM_LWLR_EN to support the unaligned LWL/LWR/SWL/SWR ops.
module mem_data_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] store_data_i,
  output logic        data_req_o,
  output logic        data_wr_o,
  output logic [1:0]  data_size_o,
  output logic [31:0] data_addr_o,
  output logic [3:0]  data_wstrb_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_addr_ok_i,
  input  logic        data_data_ok_i,
  input  logic [31:0] data_rdata_i,
  output logic        stallreq_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        addr_err_o
);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LWL_OP = 8'b1110_0010;
  localparam logic [7:0] EXE_LWR_OP = 8'b1110_0110;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
`ifdef MEM_LWLR_EN
  localparam logic [7:0] EXE_SWL_OP = 8'b1110_1010;
  localparam logic [7:0] EXE_SWR_OP = 8'b1110_1110;
`endif

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e      state_q;
  logic        kill_q;
  logic        load_q;
  logic [7:0]  op_q;
  logic [1:0]  off_q;
  logic [31:0] rt_q;

  logic        dec_mem, dec_load, dec_mis, issue_ok;
  logic [1:0]  dec_size;
  logic [31:0] dec_addr, dec_wdata;
  logic [3:0]  dec_wstrb;
  logic [1:0]  n;

  assign n = mem_addr_i[1:0];

  // LWL/LWR handled unconditionally here; they can only arrive if the decoder let them issue.
  function automatic logic [31:0] align_load(input logic [7:0] op, input logic [1:0] off,
                                             input logic [31:0] mem, input logic [31:0] rt);
    logic [31:0] sh;
    logic [15:0] h;
    sh = mem >> {off, 3'b000};
    h  = off[1] ? mem[31:16] : mem[15:0];
    case (op)
      EXE_LB_OP:  align_load = {{24{sh[7]}}, sh[7:0]};
      EXE_LBU_OP: align_load = {24'h0, sh[7:0]};
      EXE_LH_OP:  align_load = {{16{h[15]}}, h};
      EXE_LHU_OP: align_load = {16'h0, h};
      EXE_LWL_OP: align_load = (mem << {(2'd3 - off), 3'b000}) |
                               (rt & (32'hFFFF_FFFF >> ({1'b0, off, 3'b000} + 6'd8)));
      EXE_LWR_OP: align_load = sh | (rt & ~(32'hFFFF_FFFF >> {off, 3'b000}));
      default:    align_load = mem;
    endcase
  endfunction

  always_comb begin
    dec_mem   = 1'b1;
    dec_load  = 1'b0;
    dec_mis   = 1'b0;
    dec_size  = 2'd2;
    dec_addr  = mem_addr_i;
    dec_wstrb = 4'b0000;
    dec_wdata = 32'h0;
    case (aluop_i)
      EXE_LB_OP, EXE_LBU_OP: begin dec_load = 1'b1; dec_size = 2'd0; end
      EXE_LH_OP, EXE_LHU_OP: begin dec_load = 1'b1; dec_size = 2'd1; dec_mis = n[0]; end
      EXE_LW_OP:             begin dec_load = 1'b1; dec_mis = |n; end
      EXE_SB_OP: begin
        dec_size  = 2'd0;
        dec_wstrb = 4'b0001 << n;
        dec_wdata = {4{store_data_i[7:0]}};
      end
      EXE_SH_OP: begin
        dec_size  = 2'd1;
        dec_mis   = n[0];
        dec_wstrb = n[1] ? 4'b1100 : 4'b0011;
        dec_wdata = {2{store_data_i[15:0]}};
      end
      EXE_SW_OP: begin
        dec_mis   = |n;
        dec_wstrb = 4'b1111;
        dec_wdata = store_data_i;
      end
`ifdef MEM_LWLR_EN
      EXE_LWL_OP, EXE_LWR_OP: begin
        dec_load = 1'b1;
        dec_addr = {mem_addr_i[31:2], 2'b00};
      end
      EXE_SWL_OP: begin
        dec_addr  = {mem_addr_i[31:2], 2'b00};
        dec_wstrb = 4'b1111 >> (2'd3 - n);
        dec_wdata = store_data_i >> {(2'd3 - n), 3'b000};
      end
      EXE_SWR_OP: begin
        dec_addr  = {mem_addr_i[31:2], 2'b00};
        dec_wstrb = 4'b1111 << n;
        dec_wdata = store_data_i << {n, 3'b000};
      end
`endif
      default: dec_mem = 1'b0;
    endcase
  end

  assign issue_ok   = dec_mem & ~dec_mis;
  assign addr_err_o = dec_mem & dec_mis;

  // A killed transaction still drains, so it only holds the pipe when a fresh op is waiting.
  always_comb begin
    case (state_q)
      S_IDLE:         stallreq_o = issue_ok & ~flush;
      S_REQ, S_WAIT:  stallreq_o = kill_q ? (issue_ok & ~flush) : 1'b1;
      default:        stallreq_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      kill_q        <= 1'b0;
      load_q        <= 1'b0;
      op_q          <= 8'h0;
      off_q         <= 2'd0;
      rt_q          <= 32'h0;
      data_req_o    <= 1'b0;
      data_wr_o     <= 1'b0;
      data_size_o   <= 2'd0;
      data_addr_o   <= 32'h0;
      data_wstrb_o  <= 4'b0000;
      data_wdata_o  <= 32'h0;
      rdata_o       <= 32'h0;
      rdata_valid_o <= 1'b0;
    end else begin
      rdata_valid_o <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (issue_ok && !flush) begin
            state_q      <= S_REQ;
            data_req_o   <= 1'b1;
            data_wr_o    <= ~dec_load;
            data_size_o  <= dec_size;
            data_addr_o  <= dec_addr;
            data_wstrb_o <= dec_wstrb;
            data_wdata_o <= dec_wdata;
            load_q       <= dec_load;
            op_q         <= aluop_i;
            off_q        <= n;
            rt_q         <= store_data_i;
          end
        end
        S_REQ: begin
          if (flush) kill_q <= 1'b1;
          if (data_addr_ok_i) begin
            data_req_o <= 1'b0;
            if (data_data_ok_i) begin
              state_q       <= S_DONE;
              rdata_valid_o <= load_q & ~kill_q & ~flush;
              if (load_q) rdata_o <= align_load(op_q, off_q, data_rdata_i, rt_q);
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (flush) kill_q <= 1'b1;
          if (data_data_ok_i) begin
            state_q       <= S_DONE;
            rdata_valid_o <= load_q & ~kill_q & ~flush;
            if (load_q) rdata_o <= align_load(op_q, off_q, data_rdata_i, rt_q);
          end
        end
        S_DONE: begin
          kill_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_data_access.sv
// Directed bench for mem_data_access: behavioural bus slave plus a queue scoreboard
// checked by an independent monitor on the falling clock edge.
module tb_mem_data_access;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_LWL = 8'b1110_0010;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [7:0]  aluop = OP_NOP;
  logic [31:0] maddr = 32'h0;
  logic [31:0] sdata = 32'h0;
  logic        addr_ok = 1'b0;
  logic        data_ok = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic        data_req_o, data_wr_o, stallreq_o, rdata_valid_o, addr_err_o;
  logic [1:0]  data_size_o;
  logic [31:0] data_addr_o, data_wdata_o, rdata_o;
  logic [3:0]  data_wstrb_o;

  mem_data_access dut (
    .clk(clk), .rst(rst), .flush(flush),
    .aluop_i(aluop), .mem_addr_i(maddr), .store_data_i(sdata),
    .data_req_o(data_req_o), .data_wr_o(data_wr_o), .data_size_o(data_size_o),
    .data_addr_o(data_addr_o), .data_wstrb_o(data_wstrb_o), .data_wdata_o(data_wdata_o),
    .data_addr_ok_i(addr_ok), .data_data_ok_i(data_ok), .data_rdata_i(rdata),
    .stallreq_o(stallreq_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
    .addr_err_o(addr_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;

  req_t        req_q[$];
  logic [31:0] rd_q[$];
  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic push_req(input logic [31:0] a, input logic [1:0] sz, input logic wr,
                          input logic [3:0] st, input logic [31:0] wd);
    req_t r;
    r.addr = a; r.size = sz; r.wr = wr; r.wstrb = st; r.wdata = wd;
    req_q.push_back(r);
  endtask

  // Bus slave: addr_ok after addr_dly waiting cycles, data_ok data_dly cycles after acceptance.
  int          addr_dly = 0;
  int          data_dly = 0;
  logic [31:0] sl_rdata = 32'h0;
  int          sl_acnt = 0;
  int          sl_dcnt = 0;
  bit          sl_pend = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      sl_acnt = 0; sl_dcnt = 0; sl_pend = 1'b0;
    end else begin
      if (sl_pend) begin
        if (data_ok) sl_pend = 1'b0;
        else sl_dcnt++;
      end
      if (data_req_o) begin
        if (addr_ok) begin
          sl_acnt = 0;
          if (!data_ok) begin sl_pend = 1'b1; sl_dcnt = 1; end
        end else begin
          sl_acnt++;
        end
      end
    end
    #1;
    addr_ok = data_req_o && (sl_acnt >= addr_dly);
    data_ok = (addr_ok && data_dly == 0) || (sl_pend && sl_dcnt >= data_dly);
    rdata   = data_ok ? sl_rdata : 32'hDEAD_BEEF;
  end

  // Monitor: every accepted request and every valid load result is matched against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (data_req_o && addr_ok) begin
        check("req_expected", 128'(req_q.size() != 0), 128'd1);
        if (req_q.size() != 0) begin
          req_t e;
          e = req_q.pop_front();
          if (e.wr)
            check("req_store_fields", {data_addr_o, data_size_o, data_wr_o, data_wstrb_o, data_wdata_o},
                  {e.addr, e.size, e.wr, e.wstrb, e.wdata});
          else
            check("req_load_fields", {data_addr_o, data_size_o, data_wr_o}, {e.addr, e.size, e.wr});
        end
      end
      if (rdata_valid_o) begin
        check("rdata_expected", 128'(rd_q.size() != 0), 128'd1);
        if (rd_q.size() != 0) check("rdata_value", rdata_o, rd_q.pop_front());
      end
    end
  end

  task automatic run_op(input string nm, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] rt, input logic [31:0] rd, input int adly,
                        input int ddly, input int exp_stall, input logic exp_err,
                        input logic exp_valid);
    int st;
    @(posedge clk); #2;
    addr_dly = adly; data_dly = ddly; sl_rdata = rd;
    aluop = op; maddr = a; sdata = rt;
    @(negedge clk);
    check({nm, "_addr_err"}, addr_err_o, exp_err);
    st = 0;
    while (stallreq_o && st < 40) begin
      st++;
      @(negedge clk);
    end
    check({nm, "_stall_cycles"}, st, exp_stall);
    check({nm, "_rvalid"}, rdata_valid_o, exp_valid);
    @(posedge clk); #2;
    aluop = OP_NOP; maddr = 32'h0; sdata = 32'h0;
    @(negedge clk);
    check({nm, "_idle"}, {stallreq_o, data_req_o}, 2'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete, %0d/%0d so far", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", {data_req_o, data_wr_o, data_size_o, data_addr_o, data_wstrb_o,
          data_wdata_o, rdata_o, rdata_valid_o, stallreq_o, addr_err_o}, 128'd0);

    push_req(32'h8000_0003, 2'd0, 1'b0, 4'h0, 32'h0);
    rd_q.push_back(32'hFFFF_FF80);
    run_op("lb_sign", OP_LB, 32'h8000_0003, 32'h0, 32'h80FF_1234, 0, 0, 2, 1'b0, 1'b1);

    push_req(32'h0000_1002, 2'd1, 1'b1, 4'b1100, 32'hABCD_ABCD);
    run_op("sh_upper", OP_SH, 32'h0000_1002, 32'h0000_ABCD, 32'h0, 2, 1, 5, 1'b0, 1'b0);

    run_op("lw_misaligned", OP_LW, 32'h0000_1001, 32'h0, 32'h0, 0, 0, 0, 1'b1, 1'b0);
    run_op("sh_misaligned", OP_SH, 32'h0000_1001, 32'h0000_5555, 32'h0, 0, 0, 0, 1'b1, 1'b0);

    push_req(32'h8000_0001, 2'd0, 1'b0, 4'h0, 32'h0);
    rd_q.push_back(32'h0000_0012);
    run_op("lbu_zero", OP_LBU, 32'h8000_0001, 32'h0, 32'h80FF_1234, 1, 2, 5, 1'b0, 1'b1);

    push_req(32'h0000_1002, 2'd1, 1'b0, 4'h0, 32'h0);
    rd_q.push_back(32'hFFFF_8001);
    run_op("lh_sign", OP_LH, 32'h0000_1002, 32'h0, 32'h8001_7FFF, 0, 0, 2, 1'b0, 1'b1);

    push_req(32'h0000_2003, 2'd0, 1'b1, 4'b1000, 32'hA5A5_A5A5);
    run_op("sb_lane3", OP_SB, 32'h0000_2003, 32'h1234_56A5, 32'h0, 0, 1, 3, 1'b0, 1'b0);

    push_req(32'h0000_3000, 2'd2, 1'b1, 4'b1111, 32'hDEAD_BEEF);
    run_op("sw_word", OP_SW, 32'h0000_3000, 32'hDEAD_BEEF, 32'h0, 0, 0, 2, 1'b0, 1'b0);

    // Flush while waiting for data: the LHU drains silently, then the queued LW runs.
    @(posedge clk); #2;
    addr_dly = 0; data_dly = 3; sl_rdata = 32'h1234_5678;
    push_req(32'h0000_2000, 2'd1, 1'b0, 4'h0, 32'h0);
    aluop = OP_LHU; maddr = 32'h0000_2000;
    @(posedge clk); #2;
    @(posedge clk); #2;
    flush = 1'b1; aluop = OP_LW; maddr = 32'h0000_3000;
    @(posedge clk); #2;
    flush = 1'b0;
    @(negedge clk);
    check("flush_drain_stall", {stallreq_o, data_req_o}, 2'b10);
    @(negedge clk);
    @(negedge clk);
    check("flush_done_no_valid", {rdata_valid_o, stallreq_o, data_req_o}, 3'b000);
    push_req(32'h0000_3000, 2'd2, 1'b0, 4'h0, 32'h0);
    rd_q.push_back(32'hCAFE_F00D);
    sl_rdata = 32'hCAFE_F00D; data_dly = 0;
    @(negedge clk);
    check("lw_after_flush_idle", {stallreq_o, data_req_o}, 2'b10);
    st = 0;
    while (stallreq_o && st < 40) begin
      st++;
      @(negedge clk);
    end
    check("lw_after_flush_stall", st, 2);
    check("lw_after_flush_rvalid", rdata_valid_o, 1'b1);
    @(posedge clk); #2;
    aluop = OP_NOP; maddr = 32'h0;

    // Reset while in WAIT abandons the store.
    @(posedge clk); #2;
    addr_dly = 0; data_dly = 5; sl_rdata = 32'h0;
    push_req(32'h0000_5000, 2'd2, 1'b1, 4'b1111, 32'h1122_3344);
    aluop = OP_SW; maddr = 32'h0000_5000; sdata = 32'h1122_3344;
    @(posedge clk); #2;
    @(posedge clk); #2;
    @(negedge clk);
    check("rst_pre_stall", {stallreq_o, data_req_o}, 2'b10);
    rst = 1'b1; aluop = OP_NOP; maddr = 32'h0; sdata = 32'h0;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_outputs", {data_req_o, data_wr_o, data_size_o, data_addr_o, data_wstrb_o,
          data_wdata_o, rdata_o, rdata_valid_o, stallreq_o, addr_err_o}, 128'd0);

    push_req(32'h0000_6002, 2'd1, 1'b0, 4'h0, 32'h0);
    rd_q.push_back(32'h0000_9ABC);
    run_op("lhu_after_rst", OP_LHU, 32'h0000_6002, 32'h0, 32'h9ABC_1234, 0, 0, 2, 1'b0, 1'b1);

`ifdef MEM_LWLR_EN
    push_req(32'h0000_4000, 2'd2, 1'b0, 4'h0, 32'h0);
    rd_q.push_back(32'h2211_CCDD);
    run_op("lwl_merge", OP_LWL, 32'h0000_4001, 32'hAABB_CCDD, 32'h4433_2211, 0, 0, 2, 1'b0, 1'b1);
`else
    run_op("lwl_disabled", OP_LWL, 32'h0000_4001, 32'hAABB_CCDD, 32'h4433_2211, 0, 0, 0, 1'b0, 1'b0);
`endif

    repeat (2) @(negedge clk);
    check("req_queue_drained", req_q.size(), 0);
    check("rdata_queue_drained", rd_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
